carry_skip_pipelined: RTL and testbench

- Parametrised, pipelined carry-skip adder/subtractor.
- Next generation of the fixed 4-bit-block combinational carry-skip adder: block width, operand width and pipeline depth are generic; adds a subtract mode, signed-overflow flag and valid/ready flow control.
- Sits in the arithmetic datapath between operand-issue logic and result consumers; sustains one operation per clock at full throughput.

---
 rtl/carry_skip_pkg.sv | 21 ++
 rtl/carry_skip_block.sv | 32 +++
 rtl/carry_skip_pipelined.sv | 140 ++++++++++++++
 tb/tb_carry_skip_pipelined.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/carry_skip_pkg.sv
// Shared parameter helpers for the pipelined carry-skip adder/subtractor.
package carry_skip_pkg;

    function automatic bit params_ok(input int n, input int blk, input int stages);
        if ((stages < 32'sd1) || (blk < 32'sd1) || (n < blk)) begin
            return 1'b0;
        end else begin
            return ((n % blk) == 32'sd0) && (((n / blk) % stages) == 32'sd0);
        end
    endfunction

    // Blocks per stage; falls back to 1 so an illegal set still reaches the elaboration check.
    function automatic int calc_bps(input int n, input int blk, input int stages);
        if ((stages < 32'sd1) || (blk < 32'sd1) || (n < blk)) begin
            return 32'sd1;
        end else begin
            return (n / blk) / stages;
        end
    endfunction

endpackage

// File: rtl/carry_skip_block.sv
// One carry-skip cell: ripple adder over W bits with a propagate-controlled carry bypass.
module carry_skip_block #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o,
    output logic         p_o
);

    logic [W:0]   rc_s;
    logic [W-1:0] x_s;

    assign x_s = a_i ^ b_i;

    // Ripple sum and ripple carry across the block
    always_comb begin
        rc_s     = '0;
        sum_o    = '0;
        rc_s[0]  = c_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i]  = x_s[i] ^ rc_s[i];
            rc_s[i+1] = (a_i[i] & b_i[i]) | (rc_s[i] & x_s[i]);
        end
    end

    assign p_o = &x_s;
    assign c_o = p_o ? c_i : rc_s[W];

endmodule

// File: rtl/carry_skip_pipelined.sv
// Pipelined carry-skip adder/subtractor with valid/ready flow control; latency = STAGES.
module carry_skip_pipelined
    import carry_skip_pkg::*;
#(
    parameter int N      = 64,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int BPS = calc_bps(N, BLOCK, STAGES);
    localparam int SW  = BPS * BLOCK;

    if (!params_ok(N, BLOCK, STAGES)) begin : g_param_check
        $error("carry_skip_pipelined: N must be a multiple of BLOCK and N/BLOCK a multiple of STAGES>=1");
    end

    // Stage k: acc_q holds result bits for the blocks done so far and untouched A bits above them.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] carry_q;
    logic [N-1:0]      acc_q [STAGES];
    logic [N-1:0]      b_q   [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] src_v_s;
    logic [STAGES-1:0] cout_d_s;
    logic [N-1:0]      acc_d_s [STAGES];
    logic [N-1:0]      src_b_s [STAGES];
    logic              ovf_d_s;
    logic [N-1:0]      b_eff_s;
    logic              c0_s;

    assign b_eff_s = b ^ {N{sub}};
    assign c0_s    = cin ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam logic [N-1:0] MASK = N'({SW{1'b1}}) << (k * SW);

        logic [N-1:0]  src_acc_s;
        logic          src_c_s;
        logic [BPS-1:0] p_s;
        logic [SW-1:0] slice_s;

        if (k == 0) begin : g_first
            assign src_v_s[k] = in_valid;
            assign src_acc_s  = a;
            assign src_b_s[k] = b_eff_s;
            assign src_c_s    = c0_s;
        end else begin : g_next
            assign src_v_s[k] = vld_q[k-1];
            assign src_acc_s  = acc_q[k-1];
            assign src_b_s[k] = b_q[k-1];
            assign src_c_s    = carry_q[k-1];
        end

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            logic ci_s;
            logic co_s;
            if (j == 0) begin : g_cin
                assign ci_s = src_c_s;
            end else begin : g_cchain
                assign ci_s = g_blk[j-1].co_s;
            end
            carry_skip_block #(.W(BLOCK)) u_blk (
                .a_i   (src_acc_s[k*SW + j*BLOCK +: BLOCK]),
                .b_i   (src_b_s[k][k*SW + j*BLOCK +: BLOCK]),
                .c_i   (ci_s),
                .sum_o (slice_s[j*BLOCK +: BLOCK]),
                .c_o   (co_s),
                .p_o   (p_s[j])
            );
        end

        // A stage whose blocks all propagate hands its carry-in straight on.
        assign cout_d_s[k] = (&p_s) ? src_c_s : g_blk[BPS-1].co_s;
        assign acc_d_s[k]  = (src_acc_s & ~MASK) | (N'(slice_s) << (k * SW));

        if (k == STAGES - 1) begin : g_ovf
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            assign ovf_d_s = src_acc_s[N-1] ^ src_b_s[k][N-1] ^ slice_s[SW-1] ^ cout_d_s[k];
        end
    end

    // Advance chain: a slot moves when it is empty or its successor is moving
    always_comb begin
        adv_s           = '0;
        adv_s[STAGES-1] = ~vld_q[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv_s[k] = ~vld_q[k] | adv_s[k+1];
        end
    end

    // Pipeline slots: reload on advance, bubbles only clear the valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k] <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv_s[k]) begin
                    vld_q[k] <= src_v_s[k];
                    if (src_v_s[k]) begin
                        acc_q[k]   <= acc_d_s[k];
                        b_q[k]     <= src_b_s[k];
                        carry_q[k] <= cout_d_s[k];
                    end
                end
            end
            if (adv_s[STAGES-1] && src_v_s[STAGES-1]) begin
                ovf_q <= ovf_d_s;
            end
        end
    end

    assign in_ready  = adv_s[0];
    assign out_valid = vld_q[STAGES-1];
    assign sum       = acc_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_carry_skip_pipelined.sv
// Scoreboard bench for carry_skip_pipelined (N=16, BLOCK=4, STAGES=2).
module tb_carry_skip_pipelined;

    localparam int N      = 16;
    localparam int BLOCK  = 4;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cmp = 0;
    int   n_acc = 0;
    int   cyc   = 0;
    int   last_acc_cyc = 0;
    bit   done  = 1'b0;

    carry_skip_pipelined #(.N(N), .BLOCK(BLOCK), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                   input logic ci, input logic sb);
        logic [N-1:0] bb;
        logic [N:0]   full;
        exp_t         e;
        bb     = sb ? ~bv : bv;
        full   = {1'b0, av} + {1'b0, bb} + {{N{1'b0}}, ci ^ sb};
        e.sum  = full[N-1:0];
        e.cout = full[N];
        e.ovf  = (av[N-1] == bb[N-1]) && (full[N-1] != av[N-1]);
        return e;
    endfunction

    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic ci, input logic sb, input exp_t ex);
        bit ok    = 1'b0;
        int tries = 0;
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        while (!ok && tries < 200) begin
            #4;
            ok = in_ready;
            @(posedge clk);
            if (ok) begin
                exp_q.push_back(ex);
                n_vec++;
                n_acc++;
            end else begin
                tries++;
                @(negedge clk);
            end
        end
        #1;
        in_valid     = 1'b0;
        last_acc_cyc = cyc;
        if (!ok) begin
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", tries);
        end
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every presented result is compared against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_output: sum=0x%0h with empty scoreboard", sum);
                end else begin
                    chk("out_sum",  32'(sum),  32'(exp_q[0].sum));
                    chk("out_cout", 32'(cout), 32'(exp_q[0].cout));
                    chk("out_ovf",  32'(ovf),  32'(exp_q[0].ovf));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int c_first;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum",       32'(sum),       32'd0);
        chk("reset_cout",      32'(cout),      32'd0);
        chk("reset_ovf",       32'(ovf),       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Single beat: latency and one-cycle out_valid pulse
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, '{16'h2233, 1'b0, 1'b0});
        @(negedge clk); chk("lat_edge_t",   32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_edge_t1",  32'(out_valid), 32'd1);
        @(negedge clk); chk("lat_pulse_end", 32'(out_valid), 32'd0);
        drain();

        // Full skip chain and subtract/overflow cases
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
        send(16'h0003, 16'h0005, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
        drain();

        // Back-to-back throughput
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0});
        c_first = last_acc_cyc;
        send(16'h0F00, 16'h0100, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0});
        send(16'h5555, 16'h5555, 1'b0, 1'b0, '{16'hAAAA, 1'b0, 1'b1});
        send(16'h0010, 16'h0020, 1'b0, 1'b1, '{16'hFFF0, 1'b0, 1'b0});
        chk("b2b_spacing", 32'(last_acc_cyc - c_first), 32'd3);
        drain();

        // Backpressure: 6 beats, consumer stalled for 5 cycles
        @(negedge clk);
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                send(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0});
                send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
                send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0});
                send(16'h0000, 16'h0001, 1'b0, 1'b1, '{16'hFFFF, 1'b0, 1'b0});
                send(16'h1000, 16'h0100, 1'b1, 1'b1, '{16'h0EFF, 1'b1, 1'b0});
                send(16'hAAAA, 16'h5555, 1'b0, 1'b0, '{16'hFFFF, 1'b0, 1'b0});
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_accepted", 32'(n_acc - base), 32'd2);
                chk("bp_in_ready", 32'(in_ready),     32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0, '{16'h1010, 1'b0, 1'b0});
        send(16'h4000, 16'h4000, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
        #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_sum",       32'(sum),       32'd0);
        chk("midreset_cout",      32'(cout),      32'd0);
        chk("midreset_ovf",       32'(ovf),       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #4 chk("post_reset_idle", 32'(out_valid), 32'd0);
        end

        // Random operands with random bubbles and consumer stalls
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [N-1:0] ra;
                    logic [N-1:0] rb;
                    logic         rc;
                    logic         rs;
                    ra = N'($urandom);
                    rb = N'($urandom);
                    rc = 1'($urandom_range(1));
                    rs = 1'($urandom_range(1));
                    send(ra, rb, rc, rs, model(ra, rb, rc, rs));
                    if ($urandom_range(3) == 0) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
